// File: rtl/reset_boot_system.sv
// rtl/reset_boot_system.sv - reset sequencer with boot stretch, core reset and debounced button replay
//
// Purpose:
//   Stretches the asynchronous board reset into a CYCLES-long system reset,
//   issues CORE_RESET_CYCLES-long core-only resets on request, and replays the
//   full boot sequence on a debounced push-button press.
//
// Optional feature macro: RESET_BOOT_WATCHDOG_EN
//   When defined, a RUN-state watchdog replays the boot sequence if wdt_kick
//   is absent for WDT_CYCLES cycles, and sets the sticky wdt_expired flag.
//   When undefined, wdt_kick is ignored and wdt_expired is tied low.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   btn_i          in   raw asynchronous push-button, high = reset request
//   core_reset_req in   single-cycle core-only reset request
//   wdt_kick       in   watchdog service pulse
//   reset_o        out  active-high system reset
//   reset_core     out  active-high core reset
//   boot_done      out  high once the first boot sequence completes
//   reset_count    out  saturating count of accepted button resets
//   wdt_expired    out  sticky watchdog-timeout flag

module reset_boot_system #(
  parameter int CYCLES            = 20,
  parameter int CORE_RESET_CYCLES = 20,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int WDT_CYCLES        = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_i,
  input  logic       core_reset_req,
  input  logic       wdt_kick,
  output logic       reset_o,
  output logic       reset_core,
  output logic       boot_done,
  output logic [7:0] reset_count,
  output logic       wdt_expired
);

  localparam int MAX_CYC = (CYCLES > CORE_RESET_CYCLES) ? CYCLES : CORE_RESET_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_CORE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_next_cnt;
  logic               w_boot_fin;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_btn_sync;
  logic                   r_db_level;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   w_btn_event;
  logic                   w_wdt_fire;

  logic       r_reset_o;
  logic       r_reset_core;
  logic       r_boot_done;
  logic [7:0] r_reset_count;

  // Button synchronizer; resets to the released level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_i};
    end
  end

  assign w_btn_sync = r_sync[SYNC_STAGES-1];

  // Debounce: the accepted level follows the synchronized level only after
  // DEBOUNCE_CYCLES consecutive cycles of disagreement; agreement clears the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
    end else if (w_btn_sync != r_db_level) begin
      if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_db_level <= w_btn_sync;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  // Fires on the same edge the debounced level rises, so a held button
  // yields exactly one event.
  assign w_btn_event = w_btn_sync & ~r_db_level & (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

`ifdef RESET_BOOT_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] r_wdt_cnt;
  logic             r_wdt_expired;

  assign w_wdt_fire = (r_state == S_RUN) && !wdt_kick && (r_wdt_cnt == WDT_W'(WDT_CYCLES - 1));

  // Counter only runs in RUN; a button event on the same edge takes
  // precedence, so the expiry is not recorded then.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdt_cnt     <= '0;
      r_wdt_expired <= 1'b0;
    end else begin
      if ((r_state != S_RUN) || wdt_kick || w_wdt_fire || w_btn_event) begin
        r_wdt_cnt <= '0;
      end else begin
        r_wdt_cnt <= r_wdt_cnt + 1'b1;
      end
      if (w_wdt_fire && !w_btn_event) begin
        r_wdt_expired <= 1'b1;
      end
    end
  end

  assign wdt_expired = r_wdt_expired;
`else
  logic w_unused_wdt;

  assign w_unused_wdt = wdt_kick | (WDT_CYCLES == 0);
  assign w_wdt_fire   = 1'b0;
  assign wdt_expired  = 1'b0;
`endif

  // Next-state logic; priority is button event, then watchdog, then core request.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_boot_fin   = 1'b0;
    if (w_btn_event || w_wdt_fire) begin
      w_next_state = S_BOOT;
      w_next_cnt   = '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          if (r_cnt == CNT_W'(CYCLES - 1)) begin
            w_next_state = S_RUN;
            w_next_cnt   = '0;
            w_boot_fin   = 1'b1;
          end else begin
            w_next_cnt = r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (core_reset_req) begin
            w_next_state = S_CORE;
            w_next_cnt   = '0;
          end
        end
        S_CORE: begin
          if (core_reset_req) begin
            w_next_cnt = '0;
          end else if (r_cnt == CNT_W'(CORE_RESET_CYCLES - 1)) begin
            w_next_state = S_RUN;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_next_state = S_BOOT;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  // State register; outputs are registered from the next state so they
  // change on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_BOOT;
      r_cnt         <= '0;
      r_reset_o     <= 1'b1;
      r_reset_core  <= 1'b1;
      r_boot_done   <= 1'b0;
      r_reset_count <= 8'd0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_reset_o    <= (w_next_state == S_BOOT);
      r_reset_core <= (w_next_state != S_RUN);
      if (w_boot_fin) begin
        r_boot_done <= 1'b1;
      end
      if (w_btn_event && (r_reset_count != 8'hFF)) begin
        r_reset_count <= r_reset_count + 8'd1;
      end
    end
  end

  assign reset_o     = r_reset_o;
  assign reset_core  = r_reset_core;
  assign boot_done   = r_boot_done;
  assign reset_count = r_reset_count;

endmodule

// File: tb/tb_reset_boot_system.sv
// tb/tb_reset_boot_system.sv - self-checking bench for reset_boot_system
//
// Purpose:
//   Drives boot, core-reset, button, priority, watchdog and async-reset
//   scenarios and compares pulse widths, latencies and counts against values
//   derived from the block's timing rules.
//
// Optional feature macro: RESET_BOOT_WATCHDOG_EN (selects the watchdog scenario)

module tb_reset_boot_system;

  localparam int CYC   = 20;
  localparam int CORE  = 20;
  localparam int SYNC  = 2;
  localparam int DB    = 16;
  localparam int WDT   = 50;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_i = 1'b0;
  logic       core_reset_req = 1'b0;
  logic       wdt_kick = 1'b1;
  logic       reset_o;
  logic       reset_core;
  logic       boot_done;
  logic [7:0] reset_count;
  logic       wdt_expired;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  reset_boot_system #(
    .CYCLES(CYC), .CORE_RESET_CYCLES(CORE), .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DB), .WDT_CYCLES(WDT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_i(btn_i), .core_reset_req(core_reset_req),
    .wdt_kick(wdt_kick), .reset_o(reset_o), .reset_core(reset_core),
    .boot_done(boot_done), .reset_count(reset_count), .wdt_expired(wdt_expired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    int mm;
    reset_n = 1'b0;
    repeat (3) tick();
    checks += 5;
    if (reset_o !== 1'b1) begin errors++; $display("FAIL rst_reset_o: got %b expected 1", reset_o); end
    if (reset_core !== 1'b1) begin errors++; $display("FAIL rst_reset_core: got %b expected 1", reset_core); end
    if (boot_done !== 1'b0) begin errors++; $display("FAIL rst_boot_done: got %b expected 0", boot_done); end
    if (reset_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", reset_count); end
    if (wdt_expired !== 1'b0) begin errors++; $display("FAIL rst_wdt: got %b expected 0", wdt_expired); end
    reset_n = 1'b1;
    n = 0;
    mm = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
      if (reset_core !== reset_o) mm++;
      if (reset_o !== 1'b1) break;
    end
    checks += 4;
    if (n != CYC) begin errors++; $display("FAIL boot_len: got %0d expected %0d", n, CYC); end
    if (mm != 0) begin errors++; $display("FAIL boot_core_track: got %0d expected 0", mm); end
    if (boot_done !== 1'b1) begin errors++; $display("FAIL boot_done: got %b expected 1", boot_done); end
    if (reset_core !== 1'b0) begin errors++; $display("FAIL boot_core_end: got %b expected 0", reset_core); end
  endtask

  // d = 0: single request; d > 0: second request d cycles after the first.
  task automatic test_core_reset(input int d);
    int n;
    int seen_ro;
    core_reset_req = 1'b1;
    tick();
    core_reset_req = 1'b0;
    checks++;
    if (reset_core !== 1'b1) begin errors++; $display("FAIL core_start d=%0d: got %b expected 1", d, reset_core); end
    n = 1;
    seen_ro = 0;
    for (int t = 1; t < 200; t++) begin
      core_reset_req = (d != 0) && (t == d);
      tick();
      core_reset_req = 1'b0;
      if (reset_o !== 1'b0) seen_ro = 1;
      if (reset_core !== 1'b1) break;
      n++;
    end
    checks += 2;
    if (n != d + CORE) begin errors++; $display("FAIL core_len d=%0d: got %0d expected %0d", d, n, d + CORE); end
    if (seen_ro != 0) begin errors++; $display("FAIL core_reset_o d=%0d: got %0d expected 0", d, seen_ro); end
    repeat (3) tick();
  endtask

  // Press for len cycles then release for 60; a press counts only if it
  // survives the debounce window, and reset_o then rises SYNC+DB edges after the press.
  task automatic test_button(input int len);
    int rise;
    int width;
    bit ev;
    rise = 0;
    width = 0;
    ev = (len >= DB);
    for (int t = 1; t <= len + 60; t++) begin
      btn_i = (t <= len);
      tick();
      if (reset_o === 1'b1) begin
        if (rise == 0) rise = t;
        width++;
      end
    end
    btn_i = 1'b0;
    if (ev) exp_count = (exp_count < 255) ? exp_count + 1 : 255;
    checks += 3;
    if (rise != (ev ? SYNC + DB : 0)) begin errors++; $display("FAIL btn_latency len=%0d: got %0d expected %0d", len, rise, ev ? SYNC + DB : 0); end
    if (width != (ev ? CYC : 0)) begin errors++; $display("FAIL btn_width len=%0d: got %0d expected %0d", len, width, ev ? CYC : 0); end
    if (reset_count !== 8'(exp_count)) begin errors++; $display("FAIL btn_count len=%0d: got %0d expected %0d", len, reset_count, exp_count); end
  endtask

  task automatic test_button_hold();
    int width;
    width = 0;
    btn_i = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      tick();
      if (reset_o === 1'b1) width++;
    end
    btn_i = 1'b0;
    repeat (60) tick();
    exp_count = (exp_count < 255) ? exp_count + 1 : 255;
    checks += 2;
    if (width != CYC) begin errors++; $display("FAIL hold_width: got %0d expected %0d", width, CYC); end
    if (reset_count !== 8'(exp_count)) begin errors++; $display("FAIL hold_count: got %0d expected %0d", reset_count, exp_count); end
  endtask

  task automatic test_same_edge();
    btn_i = 1'b1;
    repeat (SYNC + DB - 1) tick();
    core_reset_req = 1'b1;
    tick();
    core_reset_req = 1'b0;
    exp_count = (exp_count < 255) ? exp_count + 1 : 255;
    checks += 3;
    if (reset_o !== 1'b1) begin errors++; $display("FAIL same_edge_reset_o: got %b expected 1", reset_o); end
    if (reset_core !== 1'b1) begin errors++; $display("FAIL same_edge_core: got %b expected 1", reset_core); end
    if (reset_count !== 8'(exp_count)) begin errors++; $display("FAIL same_edge_count: got %0d expected %0d", reset_count, exp_count); end
    btn_i = 1'b0;
    repeat (60) tick();
    checks += 2;
    if (reset_o !== 1'b0) begin errors++; $display("FAIL same_edge_after_o: got %b expected 0", reset_o); end
    if (reset_core !== 1'b0) begin errors++; $display("FAIL same_edge_after_core: got %b expected 0", reset_core); end
  endtask

  task automatic test_watchdog();
    int seen;
    int t;
    int width;
    int gap;
    seen = 0;
    wdt_kick = 1'b0;
    for (int k = 0; k < 5; k++) begin
      gap = $urandom_range(WDT - 10, WDT - 1);
      for (int j = 0; j < gap; j++) begin
        wdt_kick = (j == gap - 1);
        tick();
        if (reset_o !== 1'b0) seen = 1;
      end
    end
    wdt_kick = 1'b0;
    checks += 2;
    if (seen != 0) begin errors++; $display("FAIL wdt_kicked_reset: got %0d expected 0", seen); end
    if (wdt_expired !== 1'b0) begin errors++; $display("FAIL wdt_kicked_flag: got %b expected 0", wdt_expired); end
`ifdef RESET_BOOT_WATCHDOG_EN
    t = 0;
    for (int i = 1; i < 200; i++) begin
      tick();
      if (reset_o === 1'b1) begin t = i; break; end
    end
    wdt_kick = 1'b1;
    width = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (reset_o !== 1'b1) break;
      width++;
    end
    checks += 4;
    if (t != WDT) begin errors++; $display("FAIL wdt_timeout: got %0d expected %0d", t, WDT); end
    if (width != CYC) begin errors++; $display("FAIL wdt_width: got %0d expected %0d", width, CYC); end
    if (wdt_expired !== 1'b1) begin errors++; $display("FAIL wdt_flag: got %b expected 1", wdt_expired); end
    if (reset_count !== 8'(exp_count)) begin errors++; $display("FAIL wdt_count: got %0d expected %0d", reset_count, exp_count); end
`else
    t = 0;
    width = 0;
    for (int i = 1; i < 200; i++) begin
      tick();
      if (reset_o === 1'b1) t++;
      if (wdt_expired !== 1'b0) width++;
    end
    wdt_kick = 1'b1;
    checks += 2;
    if (t != 0) begin errors++; $display("FAIL wdt_off_reset: got %0d expected 0", t); end
    if (width != 0) begin errors++; $display("FAIL wdt_off_flag: got %0d expected 0", width); end
`endif
  endtask

  task automatic test_async_reset();
    core_reset_req = 1'b1;
    tick();
    core_reset_req = 1'b0;
    repeat (5) tick();
    #3;
    reset_n = 1'b0;
    #1;
    exp_count = 0;
    checks += 5;
    if (reset_o !== 1'b1) begin errors++; $display("FAIL async_reset_o: got %b expected 1", reset_o); end
    if (reset_core !== 1'b1) begin errors++; $display("FAIL async_core: got %b expected 1", reset_core); end
    if (boot_done !== 1'b0) begin errors++; $display("FAIL async_boot_done: got %b expected 0", boot_done); end
    if (reset_count !== 8'(exp_count)) begin errors++; $display("FAIL async_count: got %0d expected 0", reset_count); end
    if (wdt_expired !== 1'b0) begin errors++; $display("FAIL async_wdt: got %b expected 0", wdt_expired); end
    tick();
    reset_n = 1'b1;
    repeat (CYC + 5) tick();
    checks += 2;
    if (boot_done !== 1'b1) begin errors++; $display("FAIL reboot_done: got %b expected 1", boot_done); end
    if (reset_o !== 1'b0) begin errors++; $display("FAIL reboot_reset_o: got %b expected 0", reset_o); end
  endtask

  initial begin
    test_reset();
    test_core_reset(0);
    test_core_reset(10);
    for (int i = 0; i < 3; i++) test_core_reset($urandom_range(1, CORE - 1));
    test_button(10);
    test_button(40);
    for (int i = 0; i < 6; i++) test_button($urandom_range(1, 40));
    test_button_hold();
    test_same_edge();
    test_watchdog();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_boot_system.md
Name: reset_boot_system

Overview:
- Reset sequencer for the processor-test controller FPGA top.
- Stretches an asynchronous active-low board reset into a fixed-length active-high system reset (reset_o) for the controller.
- Generates a separately timed core reset (reset_core) on request from the controller.
- Accepts a debounced push-button reset that replays the full boot sequence.

Parameters:
- CYCLES, 20, length in clk cycles of the system reset pulse; legal range 1..65535.
- CORE_RESET_CYCLES, 20, length in clk cycles of a requested core-only reset; legal range 1..65535.
- SYNC_STAGES, 2, flip-flop depth of the button synchronizer; minimum 2.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles needed to accept a button level change; minimum 1.
- WDT_CYCLES, 1000000, watchdog timeout in clk cycles; used only with the optional feature.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset; deassertion assumed synchronous to clk externally.
- btn_i  input  1  raw, asynchronous push-button; active-high means reset request.
- core_reset_req  input  1  single-cycle pulse from the controller requesting a core-only reset.
- wdt_kick  input  1  watchdog service pulse.
- reset_o  output  1  active-high system reset.
- reset_core  output  1  active-high core reset.
- boot_done  output  1  high once the first boot sequence completes.
- reset_count  output  8  saturating count of accepted button resets.
- wdt_expired  output  1  sticky watchdog-timeout flag.

Behaviour:
- reset_n low, asynchronous: state=BOOT, counter=0, reset_o=1, reset_core=1, boot_done=0, reset_count=0, wdt_expired=0, debounce state cleared to "released".
- States: BOOT, RUN, CORE.
- BOOT:
  - reset_o=1 and reset_core=1.
  - Counter increments each rising edge.
  - After exactly CYCLES rising edges following reset_n release: reset_o=0, reset_core=0, boot_done=1, state=RUN, counter=0.
  - reset_o is therefore high for CYCLES full clock periods.
- RUN:
  - reset_o=0, reset_core=0.
  - core_reset_req=1 → next edge: state=CORE, reset_core=1, counter=0.
- CORE:
  - reset_o stays 0; reset_core=1 for exactly CORE_RESET_CYCLES cycles, then RUN.
  - A new core_reset_req during CORE restarts the count from 0 (pulse extended).
- core_reset_req in BOOT: ignored.
- Button path:
  - btn_i passes through SYNC_STAGES flops.
  - The debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch resets the debounce counter.
  - Debounced rising edge, in any state including BOOT: state=BOOT, counter=0, reset_o=1, reset_core=1, reset_count+1 (saturates at 255).
  - boot_done stays 1 if already set.
  - Holding the button produces one event; a release must be debounced before the next event.
- Priority on the same edge: button event > watchdog expiry > core_reset_req.
- Counters are wide enough for their parameter (clog2); no wrap.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- RESET_BOOT_WATCHDOG_EN defined:
  - In RUN, a WDT_CYCLES-cycle counter is cleared by wdt_kick=1.
  - On reaching WDT_CYCLES with no kick: full BOOT sequence as for a button event, except reset_count is not incremented; wdt_expired set to 1, cleared only by reset_n.
  - Counter held at 0 in BOOT and CORE.
- Not defined: wdt_kick ignored; wdt_expired tied 0; no watchdog logic synthesized. Ports exist in both builds.

Test Plan:
- Defaults; reset_n low 3 cycles then high → reset_o and reset_core high for exactly 20 edges, then both 0 and boot_done=1.
- After boot, one-cycle core_reset_req → reset_core high exactly 20 cycles, reset_o stays 0 throughout; second request at cycle 10 → reset_core high 30 cycles total.
- DEBOUNCE_CYCLES=16: btn_i high 10 cycles then low → no event; btn_i high 40 cycles → one BOOT replay (reset_o high 20 cycles), reset_count=1; held 1000 cycles → still 1.
- Button event and core_reset_req on the same edge → BOOT wins, reset_o=1, reset_count increments.
- reset_n asserted mid-CORE → all outputs immediately take reset values without waiting for clk; reset_count=0.
- With RESET_BOOT_WATCHDOG_EN and WDT_CYCLES=50: kick every 40 cycles → no reset; stop kicking → reset_o high 20 cycles after the 50th unkicked cycle, wdt_expired=1, reset_count unchanged.
